// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I fetch stage and its instruction buffer.
package fetch_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned ILEN_BYTES = 4;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO with synchronous flush.
// The head entry is read combinationally so that decode sees it in the same cycle.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int unsigned PW      = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wptr_r;
    logic [PW-1:0]    rptr_r;
    logic [PW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // A pop frees a slot in the same cycle, so push into a full FIFO is fine alongside a pop.
    always_comb begin
        pop_ok_s  = pop && (count_r != '0);
        push_ok_s = push && ((count_r != DEPTH_C) || pop_ok_s);
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            wptr_r <= push_ok_s ? wptr_r + PW'(1) : wptr_r;
            rptr_r <= pop_ok_s  ? rptr_r + PW'(1) : rptr_r;
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_r[wptr_r] <= wdata;
        end
    end

    assign rdata = mem_r[rptr_r];
    assign count = count_r;
    assign full  = (count_r == DEPTH_C);
    assign empty = (count_r == '0);

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch: owns the PC, issues credit-limited imem requests, buffers responses and handles redirects.
// Defining FETCH_PERF_EN adds a saturating decode-stall counter on port stall_cnt_o.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] stall_cnt_o
`endif
);
    localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    logic [0:0]      state_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] resp_pc_r;
    logic [CW-1:0]   outstanding_r;
    logic [CW-1:0]   drop_r;
    logic [CW-1:0]   outstanding_nxt_s;
    logic [CW-1:0]   fifo_count_s;
    logic            credit_s;
    logic            req_s;
    logic            gnt_acc_s;
    logic            rvalid_acc_s;
    logic            push_s;
    logic            pop_s;
    logic            valid_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [63:0]     head_s;

    // Credit covers buffered words plus every in-flight response, dropped ones included.
    always_comb begin
        credit_s          = ({1'b0, outstanding_r} + {1'b0, fifo_count_s}) < DEPTH_C;
        req_s             = rst_ni && (state_r == ST_RUN) && credit_s;
        gnt_acc_s         = req_s && imem_gnt_i;
        rvalid_acc_s      = rst_ni && imem_rvalid_i && (outstanding_r != '0);
        valid_s           = rst_ni && !fifo_empty_s && !redirect_i;
        pop_s             = valid_s && instr_ready_i;
        push_s            = rvalid_acc_s && (drop_r == '0) && !redirect_i && (!fifo_full_s || pop_s);
        outstanding_nxt_s = outstanding_r + CW'(gnt_acc_s) - CW'(rvalid_acc_s);
    end

    // Fetch PC, response PC, outstanding/drop counters and the boot FSM.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r       <= ST_BOOT;
            pc_r          <= word_align(RESET_PC);
            resp_pc_r     <= word_align(RESET_PC);
            outstanding_r <= '0;
            drop_r        <= '0;
        end else begin
            case (state_r)
                ST_BOOT: state_r <= ST_RUN;
                ST_RUN:  state_r <= ST_RUN;
                default: state_r <= ST_BOOT;
            endcase
            outstanding_r <= outstanding_nxt_s;
            if (redirect_i) begin
                // Everything still in flight after this edge belongs to the old path.
                pc_r      <= word_align(redirect_pc_i);
                resp_pc_r <= word_align(redirect_pc_i);
                drop_r    <= outstanding_nxt_s;
            end else begin
                pc_r      <= gnt_acc_s ? pc_r + XLEN'(ILEN_BYTES) : pc_r;
                resp_pc_r <= push_s ? resp_pc_r + XLEN'(ILEN_BYTES) : resp_pc_r;
                drop_r    <= (rvalid_acc_s && (drop_r != '0)) ? drop_r - CW'(1) : drop_r;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push_s),
        .pop    (pop_s),
        .flush  (redirect_i),
        .wdata  ({resp_pc_r, imem_rdata_i}),
        .rdata  (head_s),
        .count  (fifo_count_s),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s)
    );

    assign imem_req_o    = req_s;
    assign imem_addr_o   = rst_ni ? pc_r : 32'h0000_0000;
    assign instr_valid_o = valid_s;
    assign instr_o       = (rst_ni && !fifo_empty_s) ? head_s[31:0]  : 32'h0000_0000;
    assign pc_o          = (rst_ni && !fifo_empty_s) ? head_s[63:32] : 32'h0000_0000;

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt_r;

    // Cycles where decode holds off a valid instruction, saturating.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cnt_r <= 32'h0000_0000;
        end else if (valid_s && !instr_ready_i && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt_o = rst_ni ? stall_cnt_r : 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: in-order imem responder, expected-instruction scoreboard
// and fetch-address model. With FETCH_PERF_EN defined the stall counter is checked too.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc;
`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .instr_o       (instr),
        .pc_o          (pc)
`ifdef FETCH_PERF_EN
        ,
        .stall_cnt_o   (stall_cnt)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          gcyc;
    } pend_t;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          cyc = 0;
    int          lat = 1;
    logic        nx_rst = 1'b0;
    logic        nx_ready = 1'b1;
    logic        nx_redir = 1'b0;
    logic [31:0] nx_rpc = 32'h0;
    logic        gnt_en = 1'b1;
    logic [31:0] m_addr = RESET_PC;
    logic [31:0] stall_m = 32'h0;
    logic        want_first = 1'b0;
    logic [31:0] first_pc = 32'hDEAD_BEEF;
    pend_t       pend_q[$];
    logic [63:0] exp_q[$];
    logic        o_req, o_valid, gacc;
    logic [31:0] o_addr, o_pc, o_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, sample outputs, check, advance the models.
    task automatic tick();
        logic [63:0] e;
        @(negedge clk);
        rst_n       = nx_rst;
        instr_ready = nx_ready;
        redirect    = nx_redir;
        redirect_pc = nx_rpc;
        imem_gnt    = gnt_en;
        if (pend_q.size() > 0 && (cyc - pend_q[0].gcyc) >= lat) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_q[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        #1;
        o_req   = imem_req;
        o_addr  = imem_addr;
        o_valid = instr_valid;
        o_pc    = pc;
        o_instr = instr;
        gacc    = o_req & imem_gnt;
        if (!rst_n) begin
            check_val("rst_req_valid", {62'h0, o_req, o_valid}, 64'h0);
            check_val("rst_addr", {32'h0, o_addr}, 64'h0);
            check_val("rst_head", {o_pc, o_instr}, 64'h0);
        end else begin
            if (o_req) check_val("addr", {32'h0, o_addr}, {32'h0, m_addr});
            if (redirect) check_val("redir_gate", {63'h0, o_valid}, 64'h0);
            if (o_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("phantom", {63'h0, o_valid}, 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("instr", {o_pc, o_instr}, e);
                    if (want_first) begin
                        first_pc   = o_pc;
                        want_first = 1'b0;
                    end
                end
            end
            if (o_valid && !instr_ready && stall_m != 32'hFFFF_FFFF) stall_m++;
        end
        if (imem_rvalid) void'(pend_q.pop_front());
        if (gacc) pend_q.push_back('{addr: o_addr, gcyc: cyc});
        if (!rst_n) begin
            exp_q.delete();
            m_addr     = RESET_PC;
            stall_m    = 32'h0;
            want_first = 1'b1;
            first_pc   = 32'hDEAD_BEEF;
        end else if (redirect) begin
            exp_q.delete();
            m_addr     = {redirect_pc[31:2], 2'b00};
            want_first = 1'b1;
            first_pc   = 32'hDEAD_BEEF;
        end else if (gacc) begin
            exp_q.push_back({m_addr, mem_word(m_addr)});
            m_addr = m_addr + 32'd4;
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic wait_two_outstanding(input string tag);
        int n;
        n = 0;
        while (pend_q.size() != 2 && n < 20) begin
            tick();
            n++;
        end
        check_val(tag, pend_q.size(), 2);
    endtask

    initial begin
        int fv, gc, seen;
        logic [31:0] hold_addr;

        // Reset, then free-running fetch with single-cycle memory.
        nx_rst = 1'b0;
        tick();
        tick();
        nx_rst = 1'b1;
        fv = -1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 0) check_val("boot_req", {63'h0, o_req}, 64'h0);
            if (o_valid && fv < 0) fv = k;
        end
        check_val("first_valid_cycle", fv, 3);
        check_val("first_pc_reset", first_pc, RESET_PC);

        // Decode back-pressure: buffer fills, requests stop.
        nx_ready = 1'b0;
        gc = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k >= 4 && gacc) gc++;
        end
        check_val("stall_req", {63'h0, o_req}, 64'h0);
        check_val("stall_valid", {63'h0, o_valid}, 64'h1);
        check_val("stall_gnt", gc, 0);
`ifdef FETCH_PERF_EN
        #1;
        check_val("stall_cnt", stall_cnt, stall_m);
`endif
        nx_ready = 1'b1;
        for (int k = 0; k < 6; k++) tick();

        // Grant withheld: request and address hold steady, buffer drains.
        gnt_en = 1'b0;
        hold_addr = 32'h0;
        for (int k = 0; k < 7; k++) begin
            tick();
            if (k == 3) hold_addr = o_addr;
            if (k >= 3) begin
                check_val("hold_req", {63'h0, o_req}, 64'h1);
                check_val("hold_addr", {32'h0, o_addr}, {32'h0, hold_addr});
            end
        end
        check_val("drained", exp_q.size(), 0);

        // Redirect in the same cycle as a grant and a live response.
        gnt_en = 1'b1;
        tick();
        nx_redir = 1'b1;
        nx_rpc   = 32'h0000_0200;
        tick();
        check_val("coincide", {62'h0, o_req, imem_rvalid}, 64'h3);
        nx_redir = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check_val("first_pc_coincide", first_pc, 32'h0000_0200);

        // Redirect with two requests in flight; unaligned target.
        lat = 3;
        wait_two_outstanding("pend2_redir");
        nx_redir = 1'b1;
        nx_rpc   = 32'h0000_0103;
        tick();
        nx_redir = 1'b0;
        tick();
        check_val("redir_addr", {32'h0, o_addr}, 64'h100);
        for (int k = 0; k < 15; k++) tick();
        check_val("first_pc_redir", first_pc, 32'h0000_0100);

        // Back-to-back redirects: last one wins.
        lat = 2;
        for (int k = 0; k < 4; k++) tick();
        nx_redir = 1'b1;
        nx_rpc   = 32'h0000_0300;
        tick();
        nx_rpc   = 32'h0000_0400;
        tick();
        nx_redir = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        check_val("first_pc_b2b", first_pc, 32'h0000_0400);

        // Address wrap at the top of the address space.
        lat = 1;
        nx_redir = 1'b1;
        nx_rpc   = 32'hFFFF_FFFF;
        tick();
        nx_redir = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (gacc && o_addr == 32'h0) seen = 1;
        end
        check_val("first_pc_wrap", first_pc, 32'hFFFF_FFFC);
        check_val("wrap_seen", seen, 1);

        // Reset with two requests outstanding; late responses must be ignored.
        lat = 3;
        wait_two_outstanding("pend2_reset");
        lat = 1;
        nx_rst = 1'b0;
        tick();
        nx_rst = 1'b1;
        tick();
        check_val("reboot_req", {63'h0, o_req}, 64'h0);
        tick();
        check_val("late_rv_ignored", {63'h0, o_valid}, 64'h0);
        for (int k = 0; k < 10; k++) tick();
        check_val("first_pc_rerst", first_pc, RESET_PC);
`ifdef FETCH_PERF_EN
        #1;
        check_val("stall_cnt_rerst", stall_cnt, stall_m);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
